// File: rtl/entrada_senha.sv
// Keypad password gate: IDLE -> CHECK -> OPEN/IDLE/LOCK, with timed OPEN, PROG and LOCK windows.
// Verdict (liberado/negado) appears one cycle after CHECK; the keypad has no backpressure, only pronto.
module entrada_senha #(
    parameter logic [3:0] SENHA_PADRAO   = 4'h5,
    parameter int         MAX_TENTATIVAS = 3,
    parameter int         T_LIBERADO     = 8,
    parameter int         T_BLOQUEIO     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digito,
    input  logic       digito_valido,
    input  logic       programar,
    input  logic       igual,
    output logic [3:0] senha,
    output logic [3:0] tentativa,
    output logic       pronto,
    output logic       liberado,
    output logic       negado,
    output logic       bloqueado,
    output logic [1:0] tentativas
);

    localparam int TMAX = ((T_LIBERADO > T_BLOQUEIO) ? T_LIBERADO : T_BLOQUEIO) - 1;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

    localparam logic [TW-1:0] T_LIB_LOAD = TW'(T_LIBERADO - 1);
    localparam logic [TW-1:0] T_BLQ_LOAD = TW'(T_BLOQUEIO - 1);
    localparam logic [1:0]    MAX_CNT    = 2'(MAX_TENTATIVAS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        OPEN  = 3'd2,
        PROG  = 3'd3,
        LOCK  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    senha_q, senha_d;
    logic [3:0]    tentativa_q, tentativa_d;
    logic [1:0]    tentativas_q, tentativas_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          negado_q, negado_d;
    logic [1:0]    tent_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            senha_q      <= SENHA_PADRAO;
            tentativa_q  <= 4'h0;
            tentativas_q <= 2'd0;
            timer_q      <= '0;
            negado_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            senha_q      <= senha_d;
            tentativa_q  <= tentativa_d;
            tentativas_q <= tentativas_d;
            timer_q      <= timer_d;
            negado_q     <= negado_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        senha_d      = senha_q;
        tentativa_d  = tentativa_q;
        tentativas_d = tentativas_q;
        timer_d      = timer_q;
        negado_d     = 1'b0;
        // Saturating so a long run of misses can never roll back to zero.
        tent_inc     = (tentativas_q == 2'd3) ? 2'd3 : tentativas_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (digito_valido) begin
                    tentativa_d = digito;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (igual) begin
                    tentativas_d = 2'd0;
                    timer_d      = T_LIB_LOAD;
                    state_d      = OPEN;
                end else begin
                    tentativas_d = tent_inc;
                    negado_d     = 1'b1;
                    if (tent_inc == MAX_CNT) begin
                        timer_d = T_BLQ_LOAD;
                        state_d = LOCK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OPEN: begin
                // Timeout takes priority over a late programming request.
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else if (programar) begin
                    timer_d = T_LIB_LOAD;
                    state_d = PROG;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            PROG: begin
                if (digito_valido) begin
                    senha_d = digito;
                    timer_d = '0;
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            LOCK: begin
                if (timer_q == '0) begin
                    tentativas_d = 2'd0;
                    state_d      = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign senha      = senha_q;
    assign tentativa  = tentativa_q;
    assign tentativas = tentativas_q;
    assign negado     = negado_q;
    assign pronto     = (state_q == IDLE) || (state_q == PROG);
    assign liberado   = (state_q == OPEN) || (state_q == PROG);
    assign bloqueado  = (state_q == LOCK);

endmodule

// File: tb/tb_entrada_senha.sv
// Transaction-level bench for entrada_senha: directed scenarios followed by random code sessions.
module tb_entrada_senha;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] digito;
    logic       digito_valido;
    logic       programar;
    logic       igual;
    logic [3:0] senha;
    logic [3:0] tentativa;
    logic       pronto;
    logic       liberado;
    logic       negado;
    logic       bloqueado;
    logic [1:0] tentativas;

    entrada_senha dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .digito        (digito),
        .digito_valido (digito_valido),
        .programar     (programar),
        .igual         (igual),
        .senha         (senha),
        .tentativa     (tentativa),
        .pronto        (pronto),
        .liberado      (liberado),
        .negado        (negado),
        .bloqueado     (bloqueado),
        .tentativas    (tentativas)
    );

    assign igual = (senha == tentativa);

    always #5 clk = ~clk;

    // Reference model: the password, the consecutive-miss count and the last code entered.
    localparam int N_OPEN = 8;
    localparam int N_LOCK = 16;
    localparam int N_MAX  = 3;

    logic [3:0] m_senha = 4'h5;
    int         m_fails = 0;
    logic [3:0] m_tent  = 4'h0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk4({tag, "_senha"}, senha, 4'h5);
        chk4({tag, "_tentativa"}, tentativa, 4'h0);
        chk4({tag, "_tentativas"}, {2'b00, tentativas}, 4'd0);
        chk1({tag, "_pronto"}, pronto, 1'b1);
        chk1({tag, "_liberado"}, liberado, 1'b0);
        chk1({tag, "_negado"}, negado, 1'b0);
        chk1({tag, "_bloqueado"}, bloqueado, 1'b0);
    endtask

    // Enters one code from IDLE and checks the verdict cycle; returns at the verdict cycle.
    task automatic send_code(input logic [3:0] d, output bit ok, output bit lk);
        chk1("idle_pronto", pronto, 1'b1);
        digito        = d;
        digito_valido = 1'b1;
        tick();
        digito_valido = 1'b0;
        digito        = 4'($urandom);
        m_tent        = d;
        chk1("check_pronto", pronto, 1'b0);
        chk1("check_liberado", liberado, 1'b0);
        chk4("check_tentativa", tentativa, d);
        ok = (d == m_senha);
        if (ok) m_fails = 0;
        else if (m_fails < 3) m_fails++;
        lk = !ok && (m_fails == N_MAX);
        tick();
        chk1("verdict_liberado", liberado, ok);
        chk1("verdict_negado", negado, !ok);
        chk1("verdict_bloqueado", bloqueado, lk);
        chk4("verdict_tentativas", {2'b00, tentativas}, 4'(m_fails));
        chk4("verdict_senha", senha, m_senha);
    endtask

    task automatic idle_after_neg();
        chk1("neg_pronto", pronto, 1'b1);
        tick();
        chk1("neg_pulse_end", negado, 1'b0);
        chk1("neg_liberado", liberado, 1'b0);
        chk1("neg_pronto2", pronto, 1'b1);
    endtask

    // Starts at the first OPEN cycle. prog_at: OPEN cycle (1..8) carrying programar, other = never.
    // digit_at: PROG cycle carrying the new password, >8 = let it time out, <0 = stay in PROG and return.
    task automatic open_phase(input int prog_at, input logic [3:0] newpw, input int digit_at);
        bit in_prog = 1'b0;
        for (int i = 1; i <= N_OPEN && !in_prog; i++) begin
            chk1("open_liberado", liberado, 1'b1);
            chk1("open_pronto", pronto, 1'b0);
            programar     = (i == prog_at);
            digito        = 4'($urandom);
            digito_valido = 1'($urandom_range(0, 1));
            tick();
            programar     = 1'b0;
            digito_valido = 1'b0;
            if (i == prog_at && i < N_OPEN) in_prog = 1'b1;
        end
        if (!in_prog) begin
            chk1("open_end_liberado", liberado, 1'b0);
            chk1("open_end_pronto", pronto, 1'b1);
            chk4("open_end_tentativa", tentativa, m_tent);
            chk4("open_end_senha", senha, m_senha);
            chk4("open_end_tentativas", {2'b00, tentativas}, 4'd0);
            return;
        end
        for (int k = 1; k <= N_OPEN; k++) begin
            chk1("prog_liberado", liberado, 1'b1);
            chk1("prog_pronto", pronto, 1'b1);
            if (digit_at < 0 && k == 3) return;
            if (k == digit_at) begin
                digito        = newpw;
                digito_valido = 1'b1;
                tick();
                digito_valido = 1'b0;
                m_senha       = newpw;
                chk4("prog_new_senha", senha, newpw);
                chk1("prog_exit_liberado", liberado, 1'b0);
                chk1("prog_exit_pronto", pronto, 1'b1);
                return;
            end
            tick();
        end
        chk1("prog_timeout_liberado", liberado, 1'b0);
        chk1("prog_timeout_pronto", pronto, 1'b1);
        chk4("prog_timeout_senha", senha, m_senha);
    endtask

    // Starts at the first LOCK cycle; keypad activity throughout must be ignored.
    task automatic lock_phase();
        for (int i = 1; i <= N_LOCK; i++) begin
            chk1("lock_bloqueado", bloqueado, 1'b1);
            chk1("lock_pronto", pronto, 1'b0);
            chk1("lock_liberado", liberado, 1'b0);
            chk1("lock_negado", negado, i == 1);
            digito        = 4'h5;
            digito_valido = (i % 4 == 2) || (i == N_LOCK);
            programar     = 1'($urandom_range(0, 1));
            tick();
            digito_valido = 1'b0;
            programar     = 1'b0;
        end
        m_fails = 0;
        chk1("lock_end_bloqueado", bloqueado, 1'b0);
        chk1("lock_end_pronto", pronto, 1'b1);
        chk4("lock_end_tentativas", {2'b00, tentativas}, 4'd0);
        chk4("lock_end_tentativa", tentativa, m_tent);
        chk4("lock_end_senha", senha, m_senha);
    endtask

    task automatic session(input logic [3:0] d, input int prog_at, input logic [3:0] newpw,
                           input int digit_at);
        bit ok, lk;
        send_code(d, ok, lk);
        if (ok) open_phase(prog_at, newpw, digit_at);
        else if (lk) lock_phase();
        else idle_after_neg();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b1;
        digito        = 4'h0;
        digito_valido = 1'b0;
        programar     = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_values("reset");
        tick();
        check_reset_values("reset_hold");
        rst_n = 1'b1;

        // Correct code, plain open window, then a single miss.
        session(4'h5, 0, 4'h0, 0);
        session(4'h3, 0, 4'h0, 0);
        // Clear the miss, then three misses in a row lock the keypad.
        session(4'h5, 0, 4'h0, 0);
        session(4'h1, 0, 4'h0, 0);
        session(4'h2, 0, 4'h0, 0);
        session(4'h3, 0, 4'h0, 0);
        // Program A; old password now rejected, A accepted.
        session(4'h5, 3, 4'hA, 2);
        session(4'h5, 0, 4'h0, 0);
        session(4'hA, 0, 4'h0, 0);
        // programar on the last OPEN cycle loses to the timeout.
        session(4'hA, 8, 4'h7, 1);
        // PROG left to time out keeps the password; digit on the final PROG cycle still lands.
        session(4'hA, 1, 4'h7, 9);
        session(4'hA, 5, 4'hC, 8);
        // Reset while in PROG discards the programmed password.
        session(4'hC, 2, 4'h9, -1);
        rst_n = 1'b0;
        #1 check_reset_values("reset_in_prog");
        m_senha = 4'h5;
        m_fails = 0;
        m_tent  = 4'h0;
        tick();
        rst_n = 1'b1;
        session(4'h5, 0, 4'h0, 0);

        repeat (40) begin
            logic [3:0] code;
            code = ($urandom_range(0, 2) == 0) ? m_senha : 4'($urandom);
            session(code, int'($urandom_range(0, 9)), 4'($urandom), int'($urandom_range(0, 9)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
